// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the memory map's single CPU-side port between the instruction-fetch
//   master (read-only) and the load/store data master. Every transaction walks
//   IDLE -> ISSUE -> WAIT -> DONE, which covers the one-cycle read latency of
//   both BRAM and MMIO. The data port has priority. Once STARVE_LIMIT data
//   grants have gone by while a fetch waited, the next grant goes to fetch.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   if_req/if_addr      fetch request (held until if_ack) and address
//   if_ack/if_rdata/
//   if_err              fetch completion pulse, read data, unmapped flag
//   d_req/d_write/
//   d_addr/d_wdata      data request (held until d_ack), store flag, addr, data
//   d_ack/d_rdata/d_err data completion pulse, load data (0 for stores), flag
//   mem_addr/mem_write/
//   mem_wdata           request side of the memory-map port
//   mem_rdata           memory-map read data (valid one cycle after address)
//   mem_invalid         memory-map unmapped-address flag (combinational)
//   busy                transaction in flight
//   owner               latched winner: 0 = fetch, 1 = data
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4  // legal range 1..15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   if_req,
   input  logic [31:0]            if_addr,
   output logic                   if_ack,
   output logic [`DATA_WIDTH-1:0] if_rdata,
   output logic                   if_err,
   input  logic                   d_req,
   input  logic                   d_write,
   input  logic [31:0]            d_addr,
   input  logic [`DATA_WIDTH-1:0] d_wdata,
   output logic                   d_ack,
   output logic [`DATA_WIDTH-1:0] d_rdata,
   output logic                   d_err,
   output logic [31:0]            mem_addr,
   output logic                   mem_write,
   output logic [`DATA_WIDTH-1:0] mem_wdata,
   input  logic [`DATA_WIDTH-1:0] mem_rdata,
   input  logic                   mem_invalid,
   output logic                   busy,
   output logic                   owner
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

   state_t                   r_state;
   state_t                   w_next;
   logic                     r_owner;
   logic [31:0]              r_addr;
   logic                     r_write;
   logic [`DATA_WIDTH-1:0]   r_wdata;
   logic                     r_err;
   logic [`DATA_WIDTH-1:0]   r_rdata;
   logic [3:0]               r_starve;

   logic                     w_any_req;
   logic                     w_grant_d;

   assign w_any_req = if_req | d_req;
   // Data wins any contest unless fetch has already waited through
   // STARVE_LIMIT consecutive data grants.
   assign w_grant_d = d_req & ~(if_req & (r_starve == LP_LIMIT));

   assign busy  = (r_state != S_IDLE);
   assign owner = r_owner;

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples the values from before the edge, whatever order they appear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Request latch, starvation counter and response capture. The reset clears
   // everything, so an abandoned transaction leaves nothing behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner  <= 1'b0;
         r_addr   <= '0;
         r_write  <= 1'b0;
         r_wdata  <= '0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
         r_starve <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner <= w_grant_d;
                  if (w_grant_d) begin
                     r_addr  <= d_addr;
                     r_write <= d_write;
                     r_wdata <= d_wdata;
                     // Only data grants made over a waiting fetch count.
                     if (if_req) begin
                        r_starve <= (r_starve == LP_LIMIT) ? LP_LIMIT : r_starve + 4'd1;
                     end else begin
                        r_starve <= '0;
                     end
                  end else begin
                     r_addr   <= if_addr;
                     r_write  <= 1'b0;
                     r_wdata  <= '0;
                     r_starve <= '0;
                  end
               end
            end
            S_ISSUE: begin
               r_err <= mem_invalid;
            end
            S_WAIT: begin
               // Stores and unmapped accesses return zero, never bus contents.
               r_rdata <= (r_write || r_err) ? '0 : mem_rdata;
            end
            default: begin
            end
         endcase
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path through it can leave a signal unassigned and infer a latch.
   always_comb begin
      w_next    = r_state;
      mem_addr  = '0;
      mem_write = 1'b0;
      mem_wdata = '0;
      if_ack    = 1'b0;
      if_rdata  = '0;
      if_err    = 1'b0;
      d_ack     = 1'b0;
      d_rdata   = '0;
      d_err     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mem_addr  = r_addr;
            mem_write = r_write;
            mem_wdata = r_wdata;
            w_next    = S_WAIT;
         end
         S_WAIT: begin
            mem_addr = r_addr;
            w_next   = S_DONE;
         end
         S_DONE: begin
            if (r_owner) begin
               d_ack   = 1'b1;
               d_rdata = r_rdata;
               d_err   = r_err;
            end else begin
               if_ack   = 1'b1;
               if_rdata = r_rdata;
               if_err   = r_err;
            end
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule
